mem_responder: RTL and testbench

- Data-memory responder: the slave end of the core's load/store port.
- Accepts one word-aligned read or write request at a time over a valid/ready request channel.
- Services it from an internal word array after a fixed, parameterised latency, and returns read data plus an error flag over a valid/ready response channel.
- Sits between the CPU top level and the simulation/FPGA memory; replaces the zero-latency combinational memory path with a timed, handshaked one.

---
 rtl/mem_responder.sv | 122 ++++++++++++
 tb/tb_mem_responder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency, valid/ready handshaked word memory slave for the core's load/store port.
module mem_responder #(
  parameter int                  ADDR_LEN   = 32,
  parameter int                  DATA_LEN   = 32,
  parameter int                  DEPTH_LOG2 = 10,
  parameter logic [ADDR_LEN-1:0] BASE_ADDR  = 32'h80000000,
  parameter int                  LATENCY    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_LEN-1:0] req_addr,
  input  logic                req_wen,
  input  logic [DATA_LEN-1:0] req_wdata,
  input  logic [3:0]          req_wmask,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_LEN-1:0] resp_rdata,
  output logic                resp_err,
  output logic [31:0]         req_count
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [ADDR_LEN-1:0] addr_q, addr_d;
  logic wen_q, wen_d;
  logic [DATA_LEN-1:0] wdata_q, wdata_d;
  logic [3:0] wmask_q, wmask_d;
  logic valid_q, valid_d, err_q, err_d;
  logic [DATA_LEN-1:0] rdata_q, rdata_d;
  logic [31:0] count_q, count_d;
  logic [DATA_LEN-1:0] mem [2**DEPTH_LOG2];
  logic idle, commit, bad, we, c_wen;
  logic [ADDR_LEN-1:0] c_addr, offset;
  logic [DATA_LEN-1:0] c_wdata;
  logic [3:0] c_wmask;
  logic [DEPTH_LOG2-1:0] idx;
  assign idle = state_q == IDLE;
  assign req_ready = idle;
  // With LATENCY==1 the commit happens on the handshake edge, so decode the live request
  assign c_addr = idle ? req_addr : addr_q;
  assign c_wen = idle ? req_wen : wen_q;
  assign c_wdata = idle ? req_wdata : wdata_q;
  assign c_wmask = idle ? req_wmask : wmask_q;
  assign offset = c_addr - BASE_ADDR;
  assign bad = |offset[1:0] || c_addr < BASE_ADDR || |offset[ADDR_LEN-1:DEPTH_LOG2+2];
  assign idx = offset[DEPTH_LOG2+1:2];
  assign we = commit && c_wen && !bad && reset;
  assign resp_valid = valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err = err_q;
  assign req_count = count_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    wen_d = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    valid_d = valid_q;
    err_d = err_q;
    rdata_d = rdata_q;
    count_d = count_q;
    commit = 1'b0;
    if (idle && req_valid) begin
      addr_d = req_addr;
      wen_d = req_wen;
      wdata_d = req_wdata;
      wmask_d = req_wmask;
      count_d = count_q + 32'd1;
      cnt_d = 4'(LATENCY - 1);
      commit = LATENCY == 1;
      state_d = LATENCY == 1 ? RESP : WAIT;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q - 4'd1;
      commit = cnt_q == 4'd1;
      state_d = commit ? RESP : WAIT;
    end else if (state_q == RESP && resp_ready) begin
      state_d = IDLE;
      valid_d = 1'b0;
      err_d = 1'b0;
      rdata_d = '0;
    end
    if (commit) begin
      valid_d = 1'b1;
      err_d = bad;
      rdata_d = (bad || c_wen) ? '0 : mem[idx];
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      wen_q <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      rdata_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      wen_q <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      valid_q <= valid_d;
      err_q <= err_d;
      rdata_q <= rdata_d;
      count_q <= count_d;
    end
  end
  // Array is intentionally not reset
  always_ff @(posedge clk) begin
    if (we)
      for (int i = 0; i < 4; i++)
        if (c_wmask[i]) mem[idx][8*i +: 8] <= c_wdata[8*i +: 8];
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized self-checking bench for mem_responder at LATENCY=2 and LATENCY=1.
module tb_mem_responder;
  localparam logic [31:0] BASE = 32'h80000000;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n [2];
  logic req_valid [2], req_ready [2], req_wen [2];
  logic resp_valid [2], resp_ready [2], resp_err [2];
  logic [31:0] req_addr [2], req_wdata [2], resp_rdata [2], req_count [2];
  logic [3:0] req_wmask [2];
  int n_cmp = 0, n_bad = 0;
  logic [31:0] mm [2][1024];
  logic [31:0] cnt_m [2];
  logic [31:0] last_rdata;

  mem_responder #(.LATENCY(2)) u_l2 (
    .clk(clk), .reset(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .req_wen(req_wen[0]), .req_wdata(req_wdata[0]), .req_wmask(req_wmask[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0]), .req_count(req_count[0]));
  mem_responder #(.LATENCY(1)) u_l1 (
    .clk(clk), .reset(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .req_wen(req_wen[1]), .req_wdata(req_wdata[1]), .req_wmask(req_wmask[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1]), .req_count(req_count[1]));

  function automatic int lat(input int d);
    return d == 0 ? 2 : 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic scramble(input int d);
    req_addr[d] = $urandom;
    req_wdata[d] = $urandom;
    req_wen[d] = 1'($urandom);
    req_wmask[d] = 4'($urandom);
  endtask

  task automatic model_apply(input int d, input logic [31:0] a, input logic w, input logic [31:0] wd,
                             input logic [3:0] m, output logic [31:0] er, output logic ee);
    int idx;
    ee = a[1:0] != 2'b0 || a < BASE || (a - BASE) >= 32'd4096;
    idx = int'(((a - BASE) >> 2) & 32'h3ff);
    er = '0;
    if (!ee) begin
      if (w) begin
        for (int i = 0; i < 4; i++) if (m[i]) mm[d][idx][8*i +: 8] = wd[8*i +: 8];
      end else er = mm[d][idx];
    end
    cnt_m[d]++;
  endtask

  task automatic txn(input int d, input logic [31:0] a, input logic w, input logic [31:0] wd,
                     input logic [3:0] m, input int hold);
    logic [31:0] er;
    logic ee;
    int n;
    check("req_ready_idle", 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1;
    req_addr[d] = a;
    req_wen[d] = w;
    req_wdata[d] = wd;
    req_wmask[d] = m;
    resp_ready[d] = hold == 0;
    model_apply(d, a, w, wd, m, er, ee);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      scramble(d);
      if (resp_valid[d]) break;
    end
    check("latency", n, lat(d));
    check("rdata", resp_rdata[d], er);
    check("err", 32'(resp_err[d]), 32'(ee));
    check("count", req_count[d], cnt_m[d]);
    last_rdata = resp_rdata[d];
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      scramble(d);
      check("hold_valid", 32'(resp_valid[d]), 32'd1);
      check("hold_rdata", resp_rdata[d], er);
      check("hold_err", 32'(resp_err[d]), 32'(ee));
      check("hold_ready", 32'(req_ready[d]), 32'd0);
      check("hold_count", req_count[d], cnt_m[d]);
    end
    req_valid[d] = 1'b0;
    resp_ready[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_valid", 32'(resp_valid[d]), 32'd0);
    check("post_ready", 32'(req_ready[d]), 32'd1);
    check("post_rdata", resp_rdata[d], 32'd0);
    resp_ready[d] = 1'b0;
  endtask

  task automatic spacing(input int d);
    int l;
    logic [31:0] c0;
    l = lat(d);
    c0 = cnt_m[d];
    req_valid[d] = 1'b1;
    req_addr[d] = BASE;
    req_wen[d] = 1'b0;
    resp_ready[d] = 1'b1;
    for (int i = 0; i < 3 * (l + 1); i++) begin
      check("spc_ready", 32'(req_ready[d]), 32'(i % (l + 1) == 0));
      @(negedge clk);
      check("spc_count", req_count[d], c0 + 32'(i / (l + 1)) + 32'd1);
    end
    req_valid[d] = 1'b0;
    resp_ready[d] = 1'b0;
    cnt_m[d] += 32'd3;
    check("spc_end_ready", 32'(req_ready[d]), 32'd1);
  endtask

  task automatic reset_checks(input int d);
    check("rst_ready", 32'(req_ready[d]), 32'd1);
    check("rst_valid", 32'(resp_valid[d]), 32'd0);
    check("rst_rdata", resp_rdata[d], 32'd0);
    check("rst_err", 32'(resp_err[d]), 32'd0);
    check("rst_count", req_count[d], 32'd0);
  endtask

  task automatic reset_in_wait(input int d, input logic [31:0] a);
    req_valid[d] = 1'b1;
    req_addr[d] = a;
    req_wen[d] = 1'b1;
    req_wdata[d] = ~mm[d][int'(((a - BASE) >> 2) & 32'h3ff)];
    req_wmask[d] = 4'hf;
    resp_ready[d] = 1'b1;
    @(negedge clk);
    rst_n[d] = 1'b0;
    req_valid[d] = 1'b0;
    @(negedge clk);
    rst_n[d] = 1'b1;
    cnt_m[d] = '0;
    reset_checks(d);
    resp_ready[d] = 1'b0;
  endtask

  task automatic reset_in_resp(input int d, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] er;
    logic ee;
    int n;
    req_valid[d] = 1'b1;
    req_addr[d] = a;
    req_wen[d] = 1'b1;
    req_wdata[d] = wd;
    req_wmask[d] = 4'hf;
    resp_ready[d] = 1'b0;
    model_apply(d, a, 1'b1, wd, 4'hf, er, ee);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      req_valid[d] = 1'b0;
      if (resp_valid[d]) break;
    end
    check("rresp_latency", n, lat(d));
    rst_n[d] = 1'b0;
    @(negedge clk);
    rst_n[d] = 1'b1;
    cnt_m[d] = '0;
    reset_checks(d);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    logic [31:0] a;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0;
      req_valid[d] = 1'b0;
      resp_ready[d] = 1'b0;
      req_wen[d] = 1'b0;
      req_addr[d] = '0;
      req_wdata[d] = '0;
      req_wmask[d] = '0;
      cnt_m[d] = '0;
    end
    repeat (3) @(negedge clk);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(negedge clk);
    reset_checks(0);
    reset_checks(1);
    txn(0, BASE + 32'h10, 1'b1, 32'hDEADBEEF, 4'hf, 0);
    txn(0, BASE + 32'h10, 1'b0, 32'h0, 4'h0, 0);
    check("dir_read", last_rdata, 32'hDEADBEEF);
    check("dir_count", req_count[0], 32'd2);
    txn(0, BASE + 32'h10, 1'b1, 32'h11223344, 4'b0101, 0);
    txn(0, BASE + 32'h10, 0, 0, 0, 0);
    check("dir_merge", last_rdata, 32'hDE22BE44);
    txn(0, BASE + 32'h12, 0, 0, 0, 0);
    txn(0, 32'h7FFFFFFC, 0, 0, 0, 0);
    txn(0, BASE + 32'h1000, 0, 0, 0, 0);
    txn(0, BASE, 1'b1, 32'hCAFEF00D, 4'hf, 0);
    txn(0, BASE + 32'h1000, 1'b1, 32'hFFFFFFFF, 4'hf, 0);
    txn(0, BASE, 0, 0, 0, 0);
    check("dir_oob_write", last_rdata, 32'hCAFEF00D);
    txn(0, BASE + 32'h10, 1'b1, 32'h0, 4'h0, 0);
    txn(0, BASE + 32'h10, 0, 0, 0, 5);
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 16; w++) txn(d, BASE + 32'(4 * w), 1'b1, $urandom, 4'hf, 0);
    spacing(0);
    spacing(1);
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 40; k++) begin
        r = $urandom_range(0, 9);
        a = BASE + 32'(4 * $urandom_range(0, 15));
        if (r == 7) a = a + 32'($urandom_range(1, 3));
        else if (r == 8) a = 32'($urandom_range(0, 32'h7fffffff));
        else if (r == 9) a = BASE + 32'h1000 + 32'(4 * $urandom_range(0, 1000));
        txn(d, a, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, 3));
      end
    reset_in_wait(0, BASE + 32'h14);
    txn(0, BASE + 32'h14, 0, 0, 0, 0);
    check("rwait_count", req_count[0], 32'd1);
    for (int d = 0; d < 2; d++) begin
      reset_in_resp(d, BASE + 32'h18, 32'h5A5A0000 + 32'(d));
      txn(d, BASE + 32'h18, 0, 0, 0, 0);
      check("rresp_read", last_rdata, 32'h5A5A0000 + 32'(d));
    end
    spacing(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
